// File: rtl/ps2_morse_pkg.sv
// Shared PS/2 set-2 definitions: prefix bytes, prefix FSM states and the
// make-code to uppercase ASCII table (also used by the Morse encoder).
package ps2_morse_pkg;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } prefix_state_e;

   // Returns {hit, ascii}; hit=0 means the byte is not a supported make code.
   function automatic logic [8:0] scancode_to_ascii(input logic [7:0] code);
      logic       hit;
      logic [7:0] ascii;
      hit = 1'b1;
      case (code)
         8'h1C: ascii = 8'h41;  8'h32: ascii = 8'h42;  8'h21: ascii = 8'h43;
         8'h23: ascii = 8'h44;  8'h24: ascii = 8'h45;  8'h2B: ascii = 8'h46;
         8'h34: ascii = 8'h47;  8'h33: ascii = 8'h48;  8'h43: ascii = 8'h49;
         8'h3B: ascii = 8'h4A;  8'h42: ascii = 8'h4B;  8'h4B: ascii = 8'h4C;
         8'h3A: ascii = 8'h4D;  8'h31: ascii = 8'h4E;  8'h44: ascii = 8'h4F;
         8'h4D: ascii = 8'h50;  8'h15: ascii = 8'h51;  8'h2D: ascii = 8'h52;
         8'h1B: ascii = 8'h53;  8'h2C: ascii = 8'h54;  8'h3C: ascii = 8'h55;
         8'h2A: ascii = 8'h56;  8'h1D: ascii = 8'h57;  8'h22: ascii = 8'h58;
         8'h35: ascii = 8'h59;  8'h1A: ascii = 8'h5A;
         8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h29: ascii = 8'h20;
         default: begin
            hit   = 1'b0;
            ascii = 8'h00;
         end
      endcase
      return {hit, ascii};
   endfunction

endpackage

// File: rtl/ps2_scancode_decoder_char_fifo.sv
// Synchronous character FIFO with a registered head word; a push and a pop in
// the same cycle are both honoured, even when full.
module char_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count,
   output logic [WIDTH-1:0] head
);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             push_ok_s, pop_ok_s;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign count = count_q;
   assign head  = head_q;

   // Next-state for storage, pointers, occupancy and head word.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      pop_ok_s  = pop && !empty;
      // A pop in the same cycle frees the slot a full FIFO needs.
      push_ok_s = push && (!full || pop_ok_s);
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      // Head follows the post-edge read pointer; it holds when the FIFO drains.
      if (count_d != '0) begin
         head_d = mem_d[rd_ptr_d];
      end else begin
         head_d = head_q;
      end
   end

   // FIFO state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to ASCII characters: strips break/extended sequences,
// translates supported make codes and queues them behind a valid/ready port.
module ps2_scancode_decoder
   import ps2_morse_pkg::*;
#(
   parameter  int FIFO_DEPTH = 8,
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [7:0]     ps2_received_data,
   input  logic           ps2_received_data_strb,
   input  logic           char_ready,
   output logic           char_valid,
   output logic [7:0]     char_data,
   output logic [PTR_W:0] fifo_count,
   output logic           overflow
);

   prefix_state_e state_q, state_d;
   logic          overflow_q, overflow_d;
   logic          push_s, pop_s, full_s, empty_s;
   logic [7:0]    push_data_s;
   logic [8:0]    lookup_s;

   // Prefix FSM: only IDLE bytes are translated, everything after a prefix is dropped.
   always_comb begin
      state_d     = state_q;
      push_s      = 1'b0;
      push_data_s = 8'h00;
      lookup_s    = scancode_to_ascii(ps2_received_data);
      if (ps2_received_data_strb) begin
         case (state_q)
            ST_IDLE: begin
               if (ps2_received_data == PS2_BREAK) begin
                  state_d = ST_BRK;
               end else if (ps2_received_data == PS2_EXT) begin
                  state_d = ST_EXT;
               end else begin
                  push_s      = lookup_s[8];
                  push_data_s = lookup_s[7:0];
               end
            end
            ST_BRK:     state_d = ST_IDLE;
            ST_EXT: begin
               if (ps2_received_data == PS2_BREAK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_EXT_BRK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   assign char_valid = !empty_s;
   assign pop_s      = char_valid && char_ready;
   assign overflow   = overflow_q;

   // Sticky drop flag: a push into a full FIFO with no simultaneous pop.
   always_comb begin
      if (push_s && full_s && !pop_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Decoder state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         overflow_q <= overflow_d;
      end
   end

   char_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .full      (full_s),
      .empty     (empty_s),
      .count     (fifo_count),
      .head      (char_data)
   );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench: expected characters go into a scoreboard queue as bytes are
// strobed and are compared against char_data as the FIFO drains.
module tb_ps2_scancode_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ps2_received_data;
   logic       ps2_received_data_strb;
   logic       char_ready;
   logic       char_valid;
   logic [7:0] char_data;
   logic [3:0] fifo_count;
   logic       overflow;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] digit_codes [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] ext_seq [5] = '{8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h74};

   ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .ps2_received_data      (ps2_received_data),
      .ps2_received_data_strb (ps2_received_data_strb),
      .char_ready             (char_ready),
      .char_valid             (char_valid),
      .char_data              (char_data),
      .fifo_count             (fifo_count),
      .overflow               (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
         $error("check %s", tag);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the strobe edge.
   task automatic strobe(input logic [7:0] b);
      ps2_received_data      = b;
      ps2_received_data_strb = 1'b1;
      @(posedge clk); #1;
      ps2_received_data_strb = 1'b0;
      ps2_received_data      = 8'h00;
   endtask

   task automatic drain(input string tag);
      int budget;
      budget = 40;
      char_ready = 1'b1;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         check({tag, "_valid"}, 32'(char_valid), 32'd1);
         check({tag, "_data"}, 32'(char_data), 32'(exp_q.pop_front()));
         @(posedge clk); #1;
         budget--;
      end
      char_ready = 1'b0;
      check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check({tag, "_empty_valid"}, 32'(char_valid), 32'd0);
      check({tag, "_empty_count"}, 32'(fifo_count), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      ps2_received_data = 8'h00;
      ps2_received_data_strb = 1'b0;
      char_ready = 1'b0;
      @(posedge clk); #1;
      check("rst_valid", 32'(char_valid), 32'd0);
      check("rst_data", 32'(char_data), 32'h00);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Make/break of A
      strobe(8'h1C); exp_q.push_back(8'h41);
      @(negedge clk);
      check("a_valid_n1", 32'(char_valid), 32'd1);
      check("a_data_n1", 32'(char_data), 32'h41);
      check("a_count_n1", 32'(fifo_count), 32'd1);
      @(posedge clk); #1;
      strobe(8'hF0);
      strobe(8'h1C);
      @(negedge clk);
      check("a_break_count", 32'(fifo_count), 32'd1);
      @(posedge clk); #1;
      drain("make_break");

      // Extended keys are swallowed, then space
      for (int i = 0; i < 5; i++) strobe(ext_seq[i]);
      @(negedge clk);
      check("ext_count", 32'(fifo_count), 32'd0);
      @(posedge clk); #1;
      strobe(8'h29); exp_q.push_back(8'h20);
      @(negedge clk);
      check("space_count", 32'(fifo_count), 32'd1);
      @(posedge clk); #1;
      drain("ext_space");

      // Ordering: S O S
      strobe(8'h1B); exp_q.push_back(8'h53);
      strobe(8'h44); exp_q.push_back(8'h4F);
      strobe(8'h1B); exp_q.push_back(8'h53);
      @(negedge clk);
      check("sos_count", 32'(fifo_count), 32'd3);
      @(posedge clk); #1;
      drain("sos");

      // Overflow: nine digits into eight slots
      for (int i = 0; i < 9; i++) begin
         strobe(digit_codes[i]);
         if (i < 8) exp_q.push_back(8'h31 + 8'(i));
      end
      @(negedge clk);
      check("ovf_count", 32'(fifo_count), 32'd8);
      check("ovf_flag", 32'(overflow), 32'd1);
      @(posedge clk); #1;
      drain("overflow");
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Async reset while a break prefix is pending
      strobe(8'h1C);
      strobe(8'hF0);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(char_valid), 32'd0);
      check("arst_count", 32'(fifo_count), 32'd0);
      check("arst_data", 32'(char_data), 32'h00);
      check("arst_ovf", 32'(overflow), 32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      strobe(8'h1C); exp_q.push_back(8'h41);
      @(negedge clk);
      check("arst_make_count", 32'(fifo_count), 32'd1);
      @(posedge clk); #1;
      drain("arst_make");

      // Push and pop together while full
      for (int i = 0; i < 8; i++) begin
         strobe(digit_codes[i]);
         exp_q.push_back(8'h31 + 8'(i));
      end
      @(negedge clk);
      check("full_count", 32'(fifo_count), 32'd8);
      check("full_head", 32'(char_data), 32'(exp_q[0]));
      @(posedge clk); #1;
      char_ready = 1'b1;
      strobe(8'h45);
      char_ready = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(8'h30);
      @(negedge clk);
      check("pp_count", 32'(fifo_count), 32'd8);
      check("pp_ovf", 32'(overflow), 32'd0);
      check("pp_head", 32'(char_data), 32'(exp_q[0]));
      @(posedge clk); #1;
      drain("push_pop_full");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
